// File: rtl/fix_cksum_check.sv
// fix_cksum_check: checks the FIX "10=" trailer against the mod-256 byte sum of each message.
// Define FIX_CKSUM_ERRCNT_EN to add the saturating err_cnt output.
module fix_cksum_check #(
  parameter logic [7:0] DELIM = 8'h3B,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             msg_done,
  output logic             cksum_ok,
  output logic             cksum_err,
  output logic             fmt_err,
  output logic [7:0]       calc_sum,
  output logic [9:0]       rx_sum,
`ifdef FIX_CKSUM_ERRCNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic [CNT_W-1:0] msg_cnt
);
  typedef enum logic [2:0] {BODY, D, D1, D10, DIG} state_t;
  state_t state, state_n;
  logic [7:0] sum, sum_n, snap, snap_n;
  logic [9:0] val, val_n, val_sat;
  logic [2:0] ndig, ndig_n;
  logic bad, bad_n, end_c, fmt_c, ok_c, is_delim, is_dig;
  logic [13:0] val_mul;
  assign is_delim = in_data == DELIM;
  assign is_dig = in_data >= 8'h30 && in_data <= 8'h39;
  assign val_mul = 14'(val) * 14'd10 + 14'(in_data[3:0]);
  assign val_sat = val_mul > 14'd999 ? 10'd999 : val_mul[9:0];
  assign fmt_c = bad || ndig != 3'd3;
  assign ok_c = !fmt_c && val == {2'b00, snap};
  always_comb begin
    state_n = state;
    sum_n = sum;
    snap_n = snap;
    val_n = val;
    ndig_n = ndig;
    bad_n = bad;
    end_c = 1'b0;
    if (in_valid) begin
      if (state != DIG) sum_n = sum + in_data;
      case (state)
        BODY: if (is_delim) begin
          snap_n = sum + DELIM;
          state_n = D;
        end
        D: begin
          state_n = in_data == 8'h31 ? D1 : is_delim ? D : BODY;
          if (is_delim) snap_n = sum + DELIM;
        end
        D1: begin
          state_n = in_data == 8'h30 ? D10 : is_delim ? D : BODY;
          if (is_delim) snap_n = sum + DELIM;
        end
        D10: begin
          state_n = in_data == 8'h3D ? DIG : is_delim ? D : BODY;
          if (is_delim) snap_n = sum + DELIM;
          if (in_data == 8'h3D) begin
            val_n = '0;
            ndig_n = '0;
            bad_n = 1'b0;
          end
        end
        DIG: if (is_delim) begin
          end_c = 1'b1;
          sum_n = '0;
          state_n = BODY;
        end else if (is_dig) begin
          val_n = val_sat;
          ndig_n = ndig == 3'd4 ? 3'd4 : ndig + 3'd1;
          bad_n = bad || ndig >= 3'd3;
        end else bad_n = 1'b1;
        default: state_n = BODY;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BODY;
      sum <= '0;
      snap <= '0;
      val <= '0;
      ndig <= '0;
      bad <= 1'b0;
      msg_done <= 1'b0;
      cksum_ok <= 1'b0;
      cksum_err <= 1'b0;
      fmt_err <= 1'b0;
      calc_sum <= '0;
      rx_sum <= '0;
      msg_cnt <= '0;
    end else begin
      state <= state_n;
      sum <= sum_n;
      snap <= snap_n;
      val <= val_n;
      ndig <= ndig_n;
      bad <= bad_n;
      msg_done <= end_c;
      cksum_ok <= end_c && ok_c;
      cksum_err <= end_c && !ok_c;
      fmt_err <= end_c && fmt_c;
      if (end_c) calc_sum <= snap;
      if (end_c) rx_sum <= val;
      if (end_c && !(&msg_cnt)) msg_cnt <= msg_cnt + CNT_W'(1);
    end
  end
`ifdef FIX_CKSUM_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (end_c && !ok_c && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_fix_cksum_check.sv
// tb_fix_cksum_check: directed FIX trailer streams checked through an expected-verdict scoreboard.
module tb_fix_cksum_check;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic msg_done, cksum_ok, cksum_err, fmt_err;
  logic [7:0] calc_sum;
  logic [9:0] rx_sum;
  logic [15:0] msg_cnt, err_part;
`ifdef FIX_CKSUM_ERRCNT_EN
  logic [15:0] err_cnt;
  assign err_part = err_cnt;
`else
  assign err_part = 16'd0;
`endif
  fix_cksum_check dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .msg_done(msg_done), .cksum_ok(cksum_ok), .cksum_err(cksum_err), .fmt_err(fmt_err),
    .calc_sum(calc_sum), .rx_sum(rx_sum),
`ifdef FIX_CKSUM_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .msg_cnt(msg_cnt)
  );
  always #5 clk = ~clk;
  typedef logic [52:0] exp_t;
  exp_t q[$];
  exp_t e, act;
  int checks = 0, failures = 0, cyc = 0, exp_cnt = 0, exp_err = 0, n0;
  int done_cyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n && msg_done) begin
      done_cyc.push_back(cyc);
      act = {cksum_ok, cksum_err, fmt_err, calc_sum, rx_sum, msg_cnt, err_part};
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_msg_done act=%h exp=none", act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL verdict act=%h exp=%h", act, e);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, a, x);
    end
  endtask
  task automatic expect_msg(input bit ok, input bit fmt, input logic [7:0] calc, input logic [9:0] rx);
    exp_cnt++;
    if (!ok) exp_err++;
`ifdef FIX_CKSUM_ERRCNT_EN
    q.push_back({ok, !ok, fmt, calc, rx, 16'(exp_cnt), 16'(exp_err)});
`else
    q.push_back({ok, !ok, fmt, calc, rx, 16'(exp_cnt), 16'd0});
`endif
  endtask
  task automatic send(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data = s[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 30 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk(name, 64'(q.size()), 64'd0);
    q.delete();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {msg_done, cksum_ok, cksum_err, fmt_err, calc_sum, rx_sum, msg_cnt, err_part}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_msg(1, 0, 8'hDB, 10'd219);
    send("1=2;10=219;", 0);
    drain("drain_ok");
    expect_msg(0, 0, 8'hDB, 10'd218);
    send("1=2;10=218;", 0);
    drain("drain_mismatch");
    expect_msg(0, 1, 8'hDB, 10'd21);
    send("1=2;10=21;", 0);
    expect_msg(0, 1, 8'hDB, 10'd29);
    send("1=2;10=2x9;", 0);
    drain("drain_fmt");
    expect_msg(0, 0, 8'hDB, 10'd300);
    send("1=2;10=300;", 0);
    expect_msg(0, 1, 8'hDB, 10'd999);
    send("1=2;10=2190;", 0);
    drain("drain_bounds");
    n0 = done_cyc.size();
    expect_msg(1, 0, 8'hDB, 10'd219);
    expect_msg(1, 0, 8'hDB, 10'd219);
    send("1=2;10=219;1=2;10=219;", 0);
    drain("drain_b2b");
    if (done_cyc.size() >= n0 + 2) chk("b2b_spacing", 64'(done_cyc[n0+1] - done_cyc[n0]), 64'd11);
    else chk("b2b_pulses", 64'(done_cyc.size() - n0), 64'd2);
    send("1=2;10=2", 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_reset_cnt", 64'(msg_cnt), 64'd0);
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_err = 0;
    expect_msg(1, 0, 8'hDB, 10'd219);
    send("1=2;10=219;", 0);
    drain("drain_reset");
    expect_msg(1, 0, 8'hB5, 10'd181);
    send(";;110=5;10=181;", 1);
    drain("drain_gaps");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
